// File: rtl/instr_fetch_mem_if.sv
// Fetch/load bus between the IF-stage requester and instr_fetch_mem.
//   master : drives the load port (load_en/addr/data/done) and the fetch
//            controls (pc/req/stall/flush); observes ready/instruction/
//            instr_valid/fault.
//   slave  : the memory side; mirror image of master.
interface instr_fetch_mem_if #(
   parameter int unsigned AW = 8
);
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [7:0]    load_data;
   logic          load_done;
   logic [31:0]   pc;
   logic          req;
   logic          stall;
   logic          flush;
   logic          ready;
   logic [31:0]   instruction;
   logic          instr_valid;
   logic          fault;

   modport master (
      output load_en, load_addr, load_data, load_done, pc, req, stall, flush,
      input  ready, instruction, instr_valid, fault
   );

   modport slave (
      input  load_en, load_addr, load_data, load_done, pc, req, stall, flush,
      output ready, instruction, instr_valid, fault
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed, big-endian instruction memory with a registered fetch port.
// Program bytes are written through the load port while in LOAD; load_done
// moves to RUN, where word fetches are served with one cycle of latency.
// A load_en while in RUN performs the write and drops back to LOAD.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (memory contents are retained)
//   bus   - instr_fetch_mem_if.slave: load port, fetch controls and the
//           registered ready/instruction/instr_valid/fault outputs
module instr_fetch_mem #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned AW       = 8,
   parameter logic [31:0] NOP_WORD = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   instr_fetch_mem_if.slave      bus
);

   typedef enum logic {
      S_LOAD,
      S_RUN
   } state_t;

   logic [7:0]    r_mem [DEPTH];
   state_t        r_state;
   logic          r_ready;
   logic [31:0]   r_instruction;
   logic          r_instr_valid;
   logic          r_fault;

   logic [AW-1:0] w_a0;
   logic [AW-1:0] w_a1;
   logic [AW-1:0] w_a2;
   logic [AW-1:0] w_a3;
   logic          w_bad;
   logic [31:0]   w_word;

   // Full 32-bit pc takes part in the range check, so high bits beyond AW
   // fault instead of aliasing onto the array.
   assign w_bad  = (bus.pc[1:0] != 2'b00) || (bus.pc > 32'(DEPTH - 4));
   assign w_a0   = bus.pc[AW-1:0];
   assign w_a1   = w_a0 + AW'(1);
   assign w_a2   = w_a0 + AW'(2);
   assign w_a3   = w_a0 + AW'(3);
   assign w_word = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

   // Writes happen in both states: in LOAD normally, in RUN as the event
   // that returns to LOAD. No reset so the program image survives rst_n.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         r_mem[bus.load_addr] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_LOAD;
         r_ready       <= 1'b0;
         r_instruction <= NOP_WORD;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (bus.load_done) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            S_RUN: begin
               // Priority: load_en > flush > stall > req.
               if (bus.load_en) begin
                  r_state       <= S_LOAD;
                  r_ready       <= 1'b0;
                  r_instruction <= NOP_WORD;
                  r_instr_valid <= 1'b0;
                  r_fault       <= 1'b0;
               end else if (bus.flush) begin
                  r_instruction <= NOP_WORD;
                  r_instr_valid <= 1'b0;
                  r_fault       <= 1'b0;
               end else if (!bus.stall) begin
                  if (bus.req) begin
                     r_instr_valid <= 1'b1;
                     r_fault       <= w_bad;
                     r_instruction <= w_bad ? NOP_WORD : w_word;
                  end else begin
                     // instruction deliberately holds its last value
                     r_instr_valid <= 1'b0;
                     r_fault       <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_LOAD;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready       = r_ready;
   assign bus.instruction = r_instruction;
   assign bus.instr_valid = r_instr_valid;
   assign bus.fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model of the memory and its outputs.
module tb_instr_fetch_mem;
   localparam int unsigned DEPTH    = 256;
   localparam int unsigned AW       = 8;
   localparam logic [31:0] NOP_WORD = 32'h0;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   bit   cmp_en;

   instr_fetch_mem_if #(.AW(AW)) bus ();

   instr_fetch_mem #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .NOP_WORD(NOP_WORD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0]  m_mem [DEPTH];
   bit          m_run;
   logic [31:0] m_instr;
   bit          m_valid;
   bit          m_fault;

   function automatic logic [31:0] model_word(input logic [31:0] a);
      int p;
      p = int'(a);
      return {m_mem[p], m_mem[p+1], m_mem[p+2], m_mem[p+3]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run   = 0;
         m_valid = 0;
         m_fault = 0;
         m_instr = NOP_WORD;
      end else if (!m_run) begin
         if (bus.load_en) m_mem[int'(bus.load_addr)] = bus.load_data;
         if (bus.load_done) m_run = 1;
      end else if (bus.load_en) begin
         m_mem[int'(bus.load_addr)] = bus.load_data;
         m_run   = 0;
         m_valid = 0;
         m_fault = 0;
         m_instr = NOP_WORD;
      end else if (bus.flush) begin
         m_valid = 0;
         m_fault = 0;
         m_instr = NOP_WORD;
      end else if (!bus.stall) begin
         if (bus.req) begin
            m_valid = 1;
            m_fault = (bus.pc % 4 != 0) || (longint'(bus.pc) + 4 > longint'(DEPTH));
            m_instr = m_fault ? NOP_WORD : model_word(bus.pc);
         end else begin
            m_valid = 0;
            m_fault = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (bus.ready !== m_run) begin
            failures++;
            $display("FAIL cyc_ready t=%0t actual=%b required=%b", $time, bus.ready, m_run);
         end
         checks++;
         if (bus.instr_valid !== m_valid) begin
            failures++;
            $display("FAIL cyc_valid t=%0t actual=%b required=%b", $time, bus.instr_valid, m_valid);
         end
         checks++;
         if (bus.fault !== m_fault) begin
            failures++;
            $display("FAIL cyc_fault t=%0t actual=%b required=%b", $time, bus.fault, m_fault);
         end
         checks++;
         if (bus.instruction !== m_instr) begin
            failures++;
            $display("FAIL cyc_instr t=%0t actual=%h required=%h", $time, bus.instruction, m_instr);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.load_en   = 1'b0;
      bus.load_done = 1'b0;
      bus.req       = 1'b0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      idle();
      bus.req = 1'b1;
      bus.pc  = a;
      tick();
   endtask

   task automatic load_byte(input int a, input logic [7:0] d);
      idle();
      bus.load_en   = 1'b1;
      bus.load_addr = AW'(a);
      bus.load_data = d;
      tick();
   endtask

   task automatic finish_load();
      idle();
      bus.load_done = 1'b1;
      tick();
      idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks    = 0;
      failures  = 0;
      cmp_en    = 0;
      rst_n     = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.pc        = '0;
      idle();
      repeat (3) tick();

      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_instr", bus.instruction, NOP_WORD);

      rst_n  = 1'b1;
      cmp_en = 1;

      // Whole image random, then a known program at 4..15
      for (int i = 0; i < int'(DEPTH); i++) load_byte(i, 8'($urandom));
      load_byte(4, 8'h00);  load_byte(5, 8'h22);  load_byte(6, 8'h10);  load_byte(7, 8'h22);
      load_byte(8, 8'h11);  load_byte(9, 8'h22);  load_byte(10, 8'h33); load_byte(11, 8'h44);
      load_byte(12, 8'hde); load_byte(13, 8'had); load_byte(14, 8'hbe); load_byte(15, 8'hef);
      bus.req = 1'b1; bus.pc = 32'd4;   // req ignored in LOAD
      tick();
      chk("load_req_ignored", 32'(bus.instr_valid), 32'd0);
      finish_load();
      chk("run_ready", 32'(bus.ready), 32'd1);

      // Basic fetch and back-to-back
      fetch(32'd4);
      chk("f4_instr", bus.instruction, 32'h00221022);
      chk("f4_valid", 32'(bus.instr_valid), 32'd1);
      chk("f4_fault", 32'(bus.fault), 32'd0);
      fetch(32'd8);
      chk("b2b_8", bus.instruction, 32'h11223344);
      fetch(32'd12);
      chk("b2b_12", bus.instruction, 32'hdeadbeef);

      // req=0: valid drops, instruction holds
      idle(); tick();
      chk("noreq_valid", 32'(bus.instr_valid), 32'd0);
      chk("noreq_hold", bus.instruction, 32'hdeadbeef);

      // Stall holds pc=4 word while pc=8 is presented
      fetch(32'd4);
      for (int i = 0; i < 3; i++) begin
         bus.stall = 1'b1; bus.req = 1'b1; bus.pc = 32'd8;
         tick();
         chk("stall_hold", bus.instruction, 32'h00221022);
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      end
      bus.stall = 1'b0;
      tick();
      chk("stall_release", bus.instruction, 32'h11223344);

      // Fault boundaries
      fetch(32'd6);
      chk("mis_fault", 32'(bus.fault), 32'd1);
      chk("mis_valid", 32'(bus.instr_valid), 32'd1);
      chk("mis_instr", bus.instruction, NOP_WORD);
      fetch(32'(DEPTH - 4));
      chk("top_fault", 32'(bus.fault), 32'd0);
      chk("top_valid", 32'(bus.instr_valid), 32'd1);
      fetch(32'(DEPTH));
      chk("oor_fault", 32'(bus.fault), 32'd1);
      fetch(32'hFFFF_FF04);
      chk("hi_fault", 32'(bus.fault), 32'd1);

      // Flush with req, flush with stall
      fetch(32'd4);
      bus.flush = 1'b1;
      tick();
      chk("flush_req_valid", 32'(bus.instr_valid), 32'd0);
      chk("flush_req_instr", bus.instruction, NOP_WORD);
      fetch(32'd8);
      bus.stall = 1'b1; bus.flush = 1'b1;
      tick();
      chk("flush_stall_valid", 32'(bus.instr_valid), 32'd0);
      chk("flush_stall_instr", bus.instruction, NOP_WORD);

      // Reload from RUN
      fetch(32'd4);
      idle();
      bus.load_en = 1'b1; bus.load_addr = AW'(4); bus.load_data = 8'ha5;
      bus.req = 1'b1; bus.flush = 1'b1;
      tick();
      chk("reload_ready", 32'(bus.ready), 32'd0);
      chk("reload_valid", 32'(bus.instr_valid), 32'd0);
      idle(); bus.req = 1'b1; bus.pc = 32'd4;
      repeat (2) tick();
      chk("reload_req_ignored", 32'(bus.instr_valid), 32'd0);
      finish_load();
      fetch(32'd4);
      chk("reload_new_byte", bus.instruction, 32'ha5221022);

      // Asynchronous reset mid-fetch; image survives
      fetch(32'd8);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      chk("arst_ready", 32'(bus.ready), 32'd0);
      chk("arst_instr", bus.instruction, NOP_WORD);
      idle();
      tick();
      rst_n = 1'b1;
      finish_load();
      fetch(32'd8);
      chk("arst_retained", bus.instruction, 32'h11223344);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         idle();
         if (!m_run) begin
            bus.load_en   = ($urandom_range(0, 1) == 0);
            bus.load_done = ($urandom_range(0, 2) == 0);
         end else begin
            bus.load_en = ($urandom_range(0, 29) == 0);
         end
         bus.load_addr = AW'($urandom);
         bus.load_data = 8'($urandom);
         bus.req   = ($urandom_range(0, 3) != 0);
         bus.stall = ($urandom_range(0, 5) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0:       bus.pc = $urandom;
            1:       bus.pc = 32'(DEPTH - 4);
            2:       bus.pc = 32'(DEPTH);
            3:       bus.pc = 32'($urandom_range(0, DEPTH - 1));
            default: bus.pc = 32'($urandom_range(0, DEPTH / 4 - 1)) * 32'd4;
         endcase
         tick();
      end

      idle();
      tick();
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
